// File: rtl/sm_regdump_pkg.sv
// Shared types and constants for the debug-port register dumper.
// Frame layout: sync header, register index, then the 32-bit value MSB first.
package sm_regdump_pkg;

    typedef enum logic [1:0] {
        RdIdle  = 2'd0,
        RdFetch = 2'd1,
        RdSend  = 2'd2,
        RdDone  = 2'd3
    } rd_state_e;

    localparam logic [7:0]  RD_HDR    = 8'hA5;
    localparam int unsigned FRAME_LEN = 6;

    function automatic logic [7:0] frame_byte(input logic [2:0]  cnt,
                                              input logic [7:0]  hdr,
                                              input logic [4:0]  idx,
                                              input logic [31:0] data);
        logic [7:0] b;
        case (cnt)
            3'd0:    b = hdr;
            3'd1:    b = {3'b000, idx};
            3'd2:    b = data[31:24];
            3'd3:    b = data[23:16];
            3'd4:    b = data[15:8];
            3'd5:    b = data[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sm_regdump_if.sv
// Valid/ready byte stream carrying register-dump frames.
interface sm_regdump_if;

    logic [7:0] txData;
    logic       txValid;
    logic       txReady;

    modport master (output txData, output txValid, input txReady);
    modport slave  (input txData, input txValid, output txReady);

endinterface

// File: rtl/sm_regdump.sv
// Walks the CPU debug register port and streams each captured register as a
// 6-byte frame. The CPU keeps running, so each register is its own snapshot.
module sm_regdump
    import sm_regdump_pkg::*;
#(
    parameter int unsigned REG_FIRST = 0,
    parameter int unsigned REG_LAST  = 31,
    parameter logic [7:0]  HEADER    = RD_HDR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                single,
    input  logic [4:0]          sel,
    output logic [4:0]          regAddr,
    input  logic [31:0]         regData,
    sm_regdump_if.master        tx,
    output logic                busy,
    output logic                done
);

    if (REG_FIRST > REG_LAST || REG_LAST > 31) begin : g_range_check
        $error("sm_regdump: need REG_FIRST <= REG_LAST <= 31");
    end

    localparam logic [4:0] FirstIdx = 5'(REG_FIRST);
    localparam logic [4:0] LastIdx  = 5'(REG_LAST);
    localparam logic [2:0] LastCnt  = 3'(FRAME_LEN - 1);

    rd_state_e   state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        single_q, single_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [4:0]  start_idx;
    logic        accept;

    assign accept    = tx_valid_q & tx.txReady;
    assign start_idx = single ? sel : FirstIdx;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        single_d   = single_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        reg_addr_d = reg_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            RdIdle: begin
                if (start) begin
                    single_d   = single;
                    idx_d      = start_idx;
                    reg_addr_d = start_idx;
                    busy_d     = 1'b1;
                    state_d    = RdFetch;
                end
            end
            RdFetch: begin
                data_d     = regData;
                cnt_d      = 3'd0;
                tx_valid_d = 1'b1;
                tx_data_d  = frame_byte(3'd0, HEADER, idx_q, regData);
                state_d    = RdSend;
            end
            RdSend: begin
                if (accept) begin
                    if (cnt_q == LastCnt) begin
                        tx_valid_d = 1'b0;
                        // Equality terminal test means idx never has to wrap.
                        if (single_q || idx_q == LastIdx) begin
                            done_d  = 1'b1;
                            state_d = RdDone;
                        end else begin
                            idx_d      = idx_q + 5'd1;
                            reg_addr_d = idx_q + 5'd1;
                            state_d    = RdFetch;
                        end
                    end else begin
                        cnt_d     = cnt_q + 3'd1;
                        tx_data_d = frame_byte(cnt_q + 3'd1, HEADER, idx_q, data_q);
                    end
                end
            end
            RdDone: begin
                busy_d     = 1'b0;
                reg_addr_d = 5'd0;
                state_d    = RdIdle;
            end
            default: state_d = RdIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RdIdle;
            idx_q      <= 5'd0;
            single_q   <= 1'b0;
            cnt_q      <= 3'd0;
            data_q     <= 32'd0;
            reg_addr_q <= 5'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            single_q   <= single_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            reg_addr_q <= reg_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign regAddr    = reg_addr_q;
    assign tx.txData  = tx_data_q;
    assign tx.txValid = tx_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sm_regdump.sv
// Bench for sm_regdump: a frame-queue model of the dump checked every cycle,
// plus literal frames for the directed cases.
module tb_sm_regdump;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        single = 1'b0;
    logic [4:0]  sel = 5'd0;
    logic        start_b = 1'b0;
    logic        txReady = 1'b1;
    logic [4:0]  regAddr, regAddr_b;
    logic [31:0] regData, regData_b;
    logic        busy, done, busy_b, done_b;
    logic [31:0] regs [32];

    sm_regdump_if tx_a ();
    sm_regdump_if tx_b ();

    assign tx_a.txReady = txReady;
    assign tx_b.txReady = txReady;
    assign regData      = regs[regAddr];
    assign regData_b    = regs[regAddr_b];

    sm_regdump dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .single  (single),
        .sel     (sel),
        .regAddr (regAddr),
        .regData (regData),
        .tx      (tx_a),
        .busy    (busy),
        .done    (done)
    );

    sm_regdump #(.REG_FIRST(4), .REG_LAST(6)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_b),
        .single  (1'b0),
        .sel     (5'd0),
        .regAddr (regAddr_b),
        .regData (regData_b),
        .tx      (tx_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: on an accepted start the whole dump is expanded into a byte queue.
    logic [7:0] exp_q [$];
    logic [7:0] log_q [$];
    logic       done_due = 1'b0;
    logic       after_done = 1'b0;
    logic       model_idle = 1'b1;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'd0;
    int         done_cnt = 0;
    int         starts_acc = 0;
    int         m_lo, m_hi;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            done_due   = 1'b0;
            after_done = 1'b0;
            stall_prev = 1'b0;
            model_idle = 1'b1;
        end else begin
            chk("done", 32'(done), 32'(done_due));
            if (done) done_cnt++;
            if (after_done) chk("busy_after_done", 32'(busy), 32'd0);
            after_done = done_due;
            done_due   = 1'b0;
            if (!busy) begin
                chk("idle_valid", 32'(tx_a.txValid), 32'd0);
                chk("idle_addr", 32'(regAddr), 32'd0);
            end
            if (stall_prev) begin
                chk("stall_valid", 32'(tx_a.txValid), 32'd1);
                chk("stall_data", 32'(tx_a.txData), 32'(stall_data));
            end
            if (busy && !tx_a.txValid && !done) begin
                if (exp_q.size() >= 2) chk("fetch_addr", 32'(regAddr), 32'(exp_q[1]));
                else chk("fetch_unexpected", 32'(busy), 32'd0);
            end
            if (tx_a.txValid && txReady) begin
                log_q.push_back(tx_a.txData);
                if (exp_q.size() > 0) begin
                    chk("tx_byte", 32'(tx_a.txData), 32'(exp_q.pop_front()));
                    if (exp_q.size() == 0) done_due = 1'b1;
                end else begin
                    chk("tx_extra_byte", 32'(tx_a.txValid), 32'd0);
                end
            end
            stall_prev = tx_a.txValid && !txReady;
            stall_data = tx_a.txData;
            model_idle = (exp_q.size() == 0) && !done_due && !after_done;
            if (start && model_idle) begin
                m_lo = single ? int'(sel) : 0;
                m_hi = single ? int'(sel) : 31;
                for (int r = m_lo; r <= m_hi; r++) begin
                    exp_q.push_back(8'hA5);
                    exp_q.push_back(8'(r));
                    for (int b = 3; b >= 0; b--) exp_q.push_back(regs[r][8*b +: 8]);
                end
                starts_acc++;
                model_idle = 1'b0;
            end
        end
    end

    logic [7:0] log_b [$];
    logic [4:0] addr_b [$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_b.txValid && txReady) log_b.push_back(tx_b.txData);
            if (busy_b && !tx_b.txValid && !done_b) addr_b.push_back(regAddr_b);
        end
    end

    // 0: always ready, 1: 1,0,0 repeating, 2: random
    int ready_mode = 0;

    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       txReady = 1'b1;
                1:       begin txReady = (ph % 3 == 0); ph++; end
                default: txReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic do_start(input logic s, input logic [4:0] r);
        @(posedge clk);
        #1;
        start  = 1'b1;
        single = s;
        sel    = r;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(model_idle && !busy) && n < budget);
        chk({name, "_complete"}, 32'(n < budget), 32'd1);
    endtask

    task automatic chk_frame(input string name, input int base, input logic [4:0] idx,
                             input logic [31:0] val);
        if (log_q.size() >= base + 6) begin
            chk({name, "_hdr"}, 32'(log_q[base]), 32'h0000_00A5);
            chk({name, "_idx"}, 32'(log_q[base + 1]), 32'(idx));
            chk({name, "_val"}, {log_q[base + 2], log_q[base + 3], log_q[base + 4],
                                 log_q[base + 5]}, val);
        end else begin
            chk({name, "_len"}, 32'(log_q.size()), 32'(base + 6));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int done_before;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101;
        regs[0] = 32'hDEAD_BEEF;

        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_addr", 32'(regAddr), 32'd0);
        chk("rst_valid", 32'(tx_a.txValid), 32'd0);
        chk("rst_data", 32'(tx_a.txData), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Single register, full-rate sink.
        regs[5] = 32'h1234_5678;
        log_q.delete();
        do_start(1'b1, 5'd5);
        wait_idle(50, "single5");
        chk("single5_len", 32'(log_q.size()), 32'd6);
        chk_frame("single5", 0, 5'd5, 32'h1234_5678);
        regs[5] = 32'h0505_0505;

        // Full dump timing and content.
        log_q.delete();
        do_start(1'b0, 5'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 400);
        chk("full_done_cycle", 32'(n), 32'd225);
        wait_idle(20, "full");
        chk("full_len", 32'(log_q.size()), 32'd192);
        chk_frame("full_pc", 0, 5'd0, 32'hDEAD_BEEF);
        for (int k = 1; k < 32; k++) chk_frame("full", 6 * k, 5'(k), 32'(k) * 32'h0101_0101);

        // Backpressure 1,0,0 pattern.
        regs[3] = 32'h0BAD_F00D;
        ready_mode = 1;
        log_q.delete();
        do_start(1'b1, 5'd3);
        wait_idle(100, "bp3");
        chk("bp3_len", 32'(log_q.size()), 32'd6);
        chk_frame("bp3", 0, 5'd3, 32'h0BAD_F00D);

        // Starts while busy and in the DONE cycle are ignored.
        ready_mode  = 2;
        done_before = done_cnt;
        do_start(1'b0, 5'd0);
        n = 0;
        while (n < 3000) begin
            if (done) begin
                start  = 1'b1;
                single = 1'b1;
                sel    = 5'($urandom_range(0, 31));
                @(posedge clk);
                #1;
                start = 1'b0;
                break;
            end
            start  = (n % 5 == 0);
            single = 1'($urandom_range(0, 1));
            sel    = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        chk("ignore_finished", 32'(n < 3000), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("ignore_done_start", 32'(busy), 32'd0);
        chk("ignore_one_done", 32'(done_cnt - done_before), 32'd1);

        // Reset while byte 3 of a frame is on the bus.
        ready_mode = 0;
        regs[9] = $urandom;
        log_q.delete();
        do_start(1'b1, 5'd9);
        n = 0;
        while (log_q.size() < 3 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_mid_reached", 32'(log_q.size()), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(tx_a.txValid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_addr", 32'(regAddr), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        regs[7] = 32'hCAFE_0007;
        log_q.delete();
        do_start(1'b1, 5'd7);
        wait_idle(50, "after_rst");
        chk("after_rst_len", 32'(log_q.size()), 32'd6);
        chk_frame("after_rst", 0, 5'd7, 32'hCAFE_0007);

        // Randomized dumps checked against the model.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            ready_mode = $urandom_range(0, 2);
            do_start(1'((t % 3) != 0), 5'($urandom_range(0, 31)));
            wait_idle(1500, "random");
        end

        // Narrowed range instance: registers 4..6 only.
        ready_mode = 0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        log_b.delete();
        addr_b.delete();
        @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        n = 0;
        while (!done_b && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("range_done", 32'(done_b), 32'd1);
        chk("range_len", 32'(log_b.size()), 32'd18);
        chk("range_fetches", 32'(addr_b.size()), 32'd3);
        if (log_b.size() == 18 && addr_b.size() == 3) begin
            for (int f = 0; f < 3; f++) begin
                chk("range_hdr", 32'(log_b[6 * f]), 32'h0000_00A5);
                chk("range_idx", 32'(log_b[6 * f + 1]), 32'(4 + f));
                chk("range_val", {log_b[6 * f + 2], log_b[6 * f + 3], log_b[6 * f + 4],
                                  log_b[6 * f + 5]}, regs[4 + f]);
                chk("range_fetch_addr", 32'(addr_b[f]), 32'(4 + f));
            end
        end

        chk("starts_vs_dones", 32'(done_cnt), 32'(starts_acc - 1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
